// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch stage with a sequencer that injects interrupt-entry (and, with IFETCH_RTI_SEQ_EN, RTI) micro-op words.
// Latency: 1 cycle pc->instr; a request accepted in FETCH yields ack + first sequence word the next cycle.
// Backpressure: stall freezes state and outputs (pulses drop to 0); memory/table writes proceed regardless.
module instr_fetch_sequencer #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 32,
    parameter int ADDR_W  = 5,
    parameter int INT_LEN = 3,
    parameter int RTI_LEN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PC_W-1:0]   pc,
    input  logic              stall,
    input  logic              flush,
    input  logic              int_req,
    output logic              int_ack,
    input  logic              rti_req,
    output logic              rti_ack,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tbl_we,
    input  logic              tbl_sel,
    input  logic [2:0]        tbl_idx,
    input  logic [DATA_W-1:0] tbl_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              injecting,
    output logic              seq_done
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [2:0] INT_LAST = 3'(INT_LEN - 1);

    typedef enum logic [1:0] {FETCH, INT_SEQ, RTI_SEQ} state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                inj_q, inj_d;
    logic                done_q, done_d;
    logic                int_ack_q, int_ack_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   int_tbl_q [8];

    function automatic logic [DATA_W-1:0] int_default(input int i);
        case (i)
            0:       return DATA_W'(16'hF804);
            1:       return DATA_W'(16'hA806);
            2:       return DATA_W'(16'hB002);
            default: return '0;
        endcase
    endfunction

    // Pc wraps modulo memory depth, so the upper pc bits are deliberately ignored.
    logic unused_pc_hi;
    assign unused_pc_hi = ^pc[PC_W-1:ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) int_tbl_q[i] <= int_default(i);
        end else if (tbl_we && !tbl_sel && tbl_idx <= INT_LAST) begin
            int_tbl_q[tbl_idx] <= tbl_data;
        end
    end

`ifdef IFETCH_RTI_SEQ_EN
    localparam logic [2:0] RTI_LAST = 3'(RTI_LEN - 1);

    logic [DATA_W-1:0] rti_tbl_q [8];
    logic              rti_ack_q, rti_ack_d;

    function automatic logic [DATA_W-1:0] rti_default(input int i);
        case (i)
            0:       return DATA_W'(16'hB804);
            1:       return DATA_W'(16'hB000);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rti_tbl_q[i] <= rti_default(i);
        end else if (tbl_we && tbl_sel && tbl_idx <= RTI_LAST) begin
            rti_tbl_q[tbl_idx] <= tbl_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rti_ack_q <= 1'b0;
        else        rti_ack_q <= rti_ack_d;
    end

    assign rti_ack = rti_ack_q;
`else
    logic unused_rti;
    assign unused_rti = rti_req ^ (RTI_LEN == 0);
    assign rti_ack    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        inj_d     = inj_q;
        done_d    = 1'b0;
        int_ack_d = 1'b0;
`ifdef IFETCH_RTI_SEQ_EN
        rti_ack_d = 1'b0;
`endif
        if (!stall) begin
            case (state_q)
                FETCH: begin
                    if (int_req) begin
                        instr_d   = int_tbl_q[0];
                        valid_d   = 1'b1;
                        inj_d     = 1'b1;
                        int_ack_d = 1'b1;
                        if (INT_LEN == 1) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = INT_SEQ;
                            idx_d   = 3'd1;
                        end
                    end
`ifdef IFETCH_RTI_SEQ_EN
                    else if (rti_req) begin
                        instr_d   = rti_tbl_q[0];
                        valid_d   = 1'b1;
                        inj_d     = 1'b1;
                        rti_ack_d = 1'b1;
                        if (RTI_LEN == 1) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RTI_SEQ;
                            idx_d   = 3'd1;
                        end
                    end
`endif
                    else if (flush) begin
                        instr_d = '0;
                        valid_d = 1'b0;
                        inj_d   = 1'b0;
                    end else begin
                        instr_d = mem_q[pc[ADDR_W-1:0]];
                        valid_d = 1'b1;
                        inj_d   = 1'b0;
                    end
                end
                // Sequence words ignore flush and requests until the last word retires.
                INT_SEQ: begin
                    instr_d = int_tbl_q[idx_q];
                    valid_d = 1'b1;
                    inj_d   = 1'b1;
                    if (idx_q == INT_LAST) begin
                        done_d  = 1'b1;
                        state_d = FETCH;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
`ifdef IFETCH_RTI_SEQ_EN
                RTI_SEQ: begin
                    instr_d = rti_tbl_q[idx_q];
                    valid_d = 1'b1;
                    inj_d   = 1'b1;
                    if (idx_q == RTI_LAST) begin
                        done_d  = 1'b1;
                        state_d = FETCH;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
`endif
                default: begin
                    state_d = FETCH;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            idx_q     <= 3'd0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            inj_q     <= 1'b0;
            done_q    <= 1'b0;
            int_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            inj_q     <= inj_d;
            done_q    <= done_d;
            int_ack_q <= int_ack_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign injecting   = inj_q;
    assign seq_done    = done_q;
    assign int_ack     = int_ack_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer; RTI checks follow IFETCH_RTI_SEQ_EN.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall, flush, int_req, int_ack, rti_req, rti_ack;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        tbl_we, tbl_sel;
    logic [2:0]  tbl_idx;
    logic [15:0] tbl_data;
    logic [15:0] instr;
    logic        instr_valid, injecting, seq_done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    instr_fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .stall(stall), .flush(flush),
        .int_req(int_req), .int_ack(int_ack), .rti_req(rti_req), .rti_ack(rti_ack),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
        .instr(instr), .instr_valid(instr_valid), .injecting(injecting), .seq_done(seq_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_instr, input logic e_vld,
                           input logic e_inj, input logic e_iack, input logic e_rack,
                           input logic e_done);
        chk({tag, ".instr"},     instr,               e_instr);
        chk({tag, ".valid"},     {15'd0, instr_valid}, {15'd0, e_vld});
        chk({tag, ".injecting"}, {15'd0, injecting},  {15'd0, e_inj});
        chk({tag, ".int_ack"},   {15'd0, int_ack},    {15'd0, e_iack});
        chk({tag, ".rti_ack"},   {15'd0, rti_ack},    {15'd0, e_rack});
        chk({tag, ".seq_done"},  {15'd0, seq_done},   {15'd0, e_done});
    endtask

    initial begin
        rst_n = 1'b0; pc = '0; stall = 0; flush = 1; int_req = 0; rti_req = 0;
        wr_en = 0; wr_addr = '0; wr_data = '0;
        tbl_we = 0; tbl_sel = 0; tbl_idx = '0; tbl_data = '0;
        tick(); tick();
        chk_all("reset", 16'h0000, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Program memory with flush held so the unwritten memory is never shown.
        wr_en = 1; wr_addr = 5'd3; wr_data = 16'h1234; tick();
        wr_addr = 5'd4; wr_data = 16'h5678; tick();
        wr_addr = 5'd5; wr_data = 16'hABCD; tick();
        chk_all("flush_fetch", 16'h0000, 0, 0, 0, 0, 0);
        wr_en = 0; flush = 0;

        pc = 32'd3; tick();
        chk_all("fetch_pc3", 16'h1234, 1, 0, 0, 0, 0);
        pc = 32'd35; tick();
        chk_all("fetch_pc35_wrap", 16'h1234, 1, 0, 0, 0, 0);

        pc = 32'd4; wr_en = 1; wr_addr = 5'd4; wr_data = 16'h9999; tick();
        chk("rdw_old_data", instr, 16'h5678);
        wr_en = 0; tick();
        chk("rdw_new_data", instr, 16'h9999);

        // Interrupt entry sequence.
        pc = 32'd5; int_req = 1; tick();
        chk_all("int_w0", 16'hF804, 1, 1, 1, 0, 0);
        int_req = 0; tick();
        chk_all("int_w1", 16'hA806, 1, 1, 0, 0, 0);
        tick();
        chk_all("int_w2", 16'hB002, 1, 1, 0, 0, 1);
        tick();
        chk_all("int_after", 16'hABCD, 1, 0, 0, 0, 0);

        // Flush does not squash sequence words.
        int_req = 1; tick();
        chk("flushseq_w0", instr, 16'hF804);
        int_req = 0; flush = 1; tick();
        chk_all("flushseq_w1", 16'hA806, 1, 1, 0, 0, 0);
        tick();
        chk_all("flushseq_w2", 16'hB002, 1, 1, 0, 0, 1);
        tick();
        chk_all("flush_after_seq", 16'h0000, 0, 0, 0, 0, 0);
        flush = 0;

        // Stall on the second interrupt word.
        int_req = 1; tick();
        chk("stall_w0", instr, 16'hF804);
        int_req = 0; tick();
        chk("stall_w1", instr, 16'hA806);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("stall_hold", 16'hA806, 1, 1, 0, 0, 0);
        end
        stall = 0; tick();
        chk_all("stall_resume", 16'hB002, 1, 1, 0, 0, 1);
        tick();
        chk("stall_after", instr, 16'hABCD);

        // Stall in FETCH holds the old word despite a pc change.
        pc = 32'd3; stall = 1; tick();
        chk_all("stall_fetch", 16'hABCD, 1, 0, 0, 0, 0);
        stall = 0; tick();
        chk("unstall_fetch", instr, 16'h1234);

`ifdef IFETCH_RTI_SEQ_EN
        int_req = 1; rti_req = 1; tick();
        chk_all("both_int_w0", 16'hF804, 1, 1, 1, 0, 0);
        int_req = 0; tick();
        chk_all("both_int_w1", 16'hA806, 1, 1, 0, 0, 0);
        tick();
        chk_all("both_int_w2", 16'hB002, 1, 1, 0, 0, 1);
        tick();
        chk_all("rti_w0", 16'hB804, 1, 1, 0, 1, 0);
        rti_req = 0; tick();
        chk_all("rti_w1", 16'hB000, 1, 1, 0, 0, 1);
        tick();
        chk_all("rti_after", 16'h1234, 1, 0, 0, 0, 0);
`else
        rti_req = 1; tick();
        chk_all("rti_disabled", 16'h1234, 1, 0, 0, 0, 0);
        rti_req = 0;
`endif

        // Table rewrite, then reset mid-sequence restores defaults.
        tbl_we = 1; tbl_sel = 0; tbl_idx = 3'd1; tbl_data = 16'h0000; tick();
        tbl_we = 0; int_req = 1; tick();
        chk_all("tbl_w0", 16'hF804, 1, 1, 1, 0, 0);
        int_req = 0; tick();
        chk_all("tbl_w1_rewritten", 16'h0000, 1, 1, 0, 0, 0);
        rst_n = 0; #1;
        chk_all("async_reset", 16'h0000, 0, 0, 0, 0, 0);
        tick();
        chk_all("reset_hold", 16'h0000, 0, 0, 0, 0, 0);
        rst_n = 1; tick();
        chk_all("post_reset_fetch", 16'h1234, 1, 0, 0, 0, 0);
        int_req = 1; tick();
        chk("post_reset_w0", instr, 16'hF804);
        int_req = 0; tick();
        chk("post_reset_w1_default", instr, 16'hA806);
        tick();
        chk_all("post_reset_w2", 16'hB002, 1, 1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
